// File: rtl/cpu_pkg.sv
// Shared widths, the issued-operation record and FSM state encodings for the
// ID-to-ALU issue path.
package cpu_pkg;

  localparam int OP_W   = 5;
  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] rd;
  } issue_op_t;

  typedef enum logic {
    U_IDLE,
    U_ACK
  } up_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_REQ,
    D_RTZ
  } dn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop level synchroniser for a single asynchronous handshake line.
module sync_2ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/alu_issue_buffer.sv
// Elastic ID-to-ALU hand-off: four-phase handshake in, small FIFO, four-phase
// handshake out, with flush of queued (not yet issued) work.
module alu_issue_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_req,
  output logic                       in_ack,
  input  logic [OP_W-1:0]            in_opcode,
  input  logic [DATA_W-1:0]          in_a,
  input  logic [DATA_W-1:0]          in_b,
  input  logic [REG_AW-1:0]          in_rd,
  output logic                       out_req,
  input  logic                       out_ack,
  output logic [OP_W-1:0]            out_opcode,
  output logic [DATA_W-1:0]          out_a,
  output logic [DATA_W-1:0]          out_b,
  output logic [REG_AW-1:0]          out_rd,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic      req_s, ack_s;
  up_state_t u_state, u_next;
  dn_state_t d_state, d_next;

  logic [AW:0] wr_ptr, rd_ptr;
  issue_op_t   mem [DEPTH];
  issue_op_t   in_op;
  issue_op_t   out_op_p0;
  logic        full, empty, push, wr_en, pop;

  // Handshake inputs cross into the clk domain here
  sync_2ff #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (reset),
    .d   (in_req),
    .q   (req_s)
  );

  sync_2ff #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (reset),
    .d   (out_ack),
    .q   (ack_s)
  );

  assign in_op = {in_opcode, in_a, in_b, in_rd};
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = CW'(wr_ptr - rd_ptr);

  // Full is judged before any same-cycle pop; flush drops both push data and pop
  assign push  = (u_state == U_IDLE) && req_s && !full;
  assign wr_en = push && !flush;
  assign pop   = (d_state == D_IDLE) && !empty && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_state <= U_IDLE;
      d_state <= D_IDLE;
    end else begin
      u_state <= u_next;
      d_state <= d_next;
    end
  end

  always_comb begin
    u_next = u_state;
    d_next = d_state;
    case (u_state)
      U_IDLE:  if (push)   u_next = U_ACK;
      U_ACK:   if (!req_s) u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase
    case (d_state)
      D_IDLE:  if (pop)    d_next = D_REQ;
      D_REQ:   if (ack_s)  d_next = D_RTZ;
      D_RTZ:   if (!ack_s) d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  always_comb begin
    in_ack  = 1'b0;
    out_req = 1'b0;
    if (u_state == U_ACK) in_ack  = 1'b1;
    if (d_state == D_REQ) out_req = 1'b1;
  end

  // Pointers carry one extra wrap bit so full and empty stay distinguishable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= in_op;
  end

  // Issue register: stable for the whole out_req/out_ack cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    out_op_p0 <= '0;
    else if (pop) out_op_p0 <= mem[rd_ptr[AW-1:0]];
  end

  assign out_opcode = out_op_p0.opcode;
  assign out_a      = out_op_p0.a;
  assign out_b      = out_op_p0.b;
  assign out_rd     = out_op_p0.rd;

endmodule
